// File: rtl/conv1d_feeder_pkg.sv
// Shared types and constants for the conv1d sample feeder (OBI copy engine).
package conv1d_feeder_pkg;

    localparam int unsigned MAX_LEN_DEFAULT = 1024;

    // Register word indices, decoded from reg_addr_i[4:2]
    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_SRC    = 3'd2;
    localparam logic [2:0] OFF_DST    = 3'd3;
    localparam logic [2:0] OFF_LEN    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/conv1d_feeder_regs.sv
// Host-visible configuration registers for the feeder: decode, storage, error and read mux.
module conv1d_feeder_regs
    import conv1d_feeder_pkg::*;
#(
    parameter  int unsigned MaxLen = MAX_LEN_DEFAULT,
    localparam int unsigned CntW   = $clog2(MaxLen + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            reg_valid_i,
    input  logic            reg_write_i,
    input  logic [3:0]      reg_wstrb_i,
    input  logic [31:0]     reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic            reg_error_o,
    output logic            reg_ready_o,
    output logic [31:0]     reg_rdata_o,
    input  logic            busy_i,
    input  logic            done_set_i,
    input  logic            start_acc_i,
    output logic            start_req_o,
    output logic            irq_en_o,
    output logic [31:0]     src_o,
    output logic [31:0]     dst_o,
    output logic [CntW-1:0] len_o
);

    logic [2:0]      idx;
    logic            err;
    logic            wr;
    logic            irq_en_q, irq_en_d;
    logic            done_q, done_d;
    logic [31:2]     src_q, src_d;
    logic [31:2]     dst_q, dst_d;
    logic [CntW-1:0] len_q, len_d;
    logic            unused_bits;

    assign idx         = reg_addr_i[4:2];
    assign unused_bits = ^{reg_wstrb_i, reg_addr_i[31:5], reg_addr_i[1:0]};

    always_comb begin
        err = 1'b0;
        if (reg_valid_i) begin
            if (idx > OFF_LEN) begin
                err = 1'b1;
            end else if (reg_write_i && busy_i &&
                         (idx == OFF_SRC || idx == OFF_DST || idx == OFF_LEN)) begin
                err = 1'b1;
            end
        end
    end

    assign wr          = reg_valid_i && reg_write_i && !err;
    assign reg_error_o = err;
    assign reg_ready_o = reg_valid_i;
    assign start_req_o = wr && (idx == OFF_CTRL) && reg_wdata_i[0];

    always_comb begin
        irq_en_d = irq_en_q;
        done_d   = done_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        if (wr && idx == OFF_CTRL)   irq_en_d = reg_wdata_i[1];
        if (wr && idx == OFF_SRC)    src_d    = reg_wdata_i[31:2];
        if (wr && idx == OFF_DST)    dst_d    = reg_wdata_i[31:2];
        if (wr && idx == OFF_LEN) begin
            len_d = (reg_wdata_i > 32'(MaxLen)) ? CntW'(MaxLen) : reg_wdata_i[CntW-1:0];
        end
        if (start_acc_i) done_d = 1'b0;
        if (wr && idx == OFF_STATUS && reg_wdata_i[1]) done_d = 1'b0;
        // A completion in the same cycle as a clear wins: software has not seen it yet.
        if (done_set_i) done_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
        end else begin
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        reg_rdata_o = '0;
        if (reg_valid_i && !reg_write_i && !err) begin
            case (idx)
                OFF_CTRL:   reg_rdata_o = {30'd0, irq_en_q, 1'b0};
                OFF_STATUS: reg_rdata_o = {30'd0, done_q, busy_i};
                OFF_SRC:    reg_rdata_o = {src_q, 2'b00};
                OFF_DST:    reg_rdata_o = {dst_q, 2'b00};
                OFF_LEN:    reg_rdata_o = 32'(len_q);
                default:    reg_rdata_o = '0;
            endcase
        end
    end

    assign irq_en_o = irq_en_q;
    assign src_o    = {src_q, 2'b00};
    assign dst_o    = {dst_q, 2'b00};
    assign len_o    = len_q;

endmodule

// File: rtl/conv1d_feeder.sv
// Copies LEN words from SRC to DST over an OBI manager port, one outstanding access at a time.
module conv1d_feeder
    import conv1d_feeder_pkg::*;
#(
    parameter int unsigned MaxLen = MAX_LEN_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [3:0]  reg_wstrb_i,
    input  logic [31:0] reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    output logic        reg_error_o,
    output logic        reg_ready_o,
    output logic [31:0] reg_rdata_o,
    output logic        mgr_req_o,
    output logic        mgr_we_o,
    output logic [3:0]  mgr_be_o,
    output logic [31:0] mgr_addr_o,
    output logic [31:0] mgr_wdata_o,
    input  logic        mgr_gnt_i,
    input  logic        mgr_rvalid_i,
    input  logic [31:0] mgr_rdata_i,
    output logic        done_int_o
);

    localparam int unsigned CntW = $clog2(MaxLen + 1);

    feeder_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            busy, start_req, start_acc, irq_en;
    logic [31:0]     src, dst, word_off;
    logic [CntW-1:0] len;

    conv1d_feeder_regs #(.MaxLen(MaxLen)) u_regs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .reg_valid_i (reg_valid_i),
        .reg_write_i (reg_write_i),
        .reg_wstrb_i (reg_wstrb_i),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_error_o (reg_error_o),
        .reg_ready_o (reg_ready_o),
        .reg_rdata_o (reg_rdata_o),
        .busy_i      (busy),
        .done_set_i  (state_q == ST_DONE),
        .start_acc_i (start_acc),
        .start_req_o (start_req),
        .irq_en_o    (irq_en),
        .src_o       (src),
        .dst_o       (dst),
        .len_o       (len)
    );

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign start_acc = start_req && (state_q == ST_IDLE);
    assign word_off  = 32'({cnt_q, 2'b00});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        mgr_req_o   = 1'b0;
        mgr_we_o    = 1'b0;
        mgr_be_o    = 4'h0;
        mgr_addr_o  = '0;
        mgr_wdata_o = '0;
        done_int_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    cnt_d   = '0;
                    state_d = (len == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                mgr_req_o  = 1'b1;
                mgr_be_o   = 4'hF;
                mgr_addr_o = src + word_off;
                if (mgr_gnt_i) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mgr_rvalid_i) begin
                    data_d  = mgr_rdata_i;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                mgr_req_o   = 1'b1;
                mgr_we_o    = 1'b1;
                mgr_be_o    = 4'hF;
                mgr_addr_o  = dst + word_off;
                mgr_wdata_o = data_q;
                if (mgr_gnt_i) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mgr_rvalid_i) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == len) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: begin
                done_int_o = irq_en;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_conv1d_feeder.sv
// Directed plus randomized bench for conv1d_feeder with an OBI memory model and transfer scoreboard.
module tb_conv1d_feeder;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        reg_valid_i, reg_write_i;
    logic [3:0]  reg_wstrb_i;
    logic [31:0] reg_addr_i, reg_wdata_i;
    logic        reg_error_o, reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        mgr_req_o, mgr_we_o;
    logic [3:0]  mgr_be_o;
    logic [31:0] mgr_addr_o, mgr_wdata_o;
    logic        mgr_gnt_i = 1'b0, mgr_rvalid_i = 1'b0;
    logic [31:0] mgr_rdata_i = '0;
    logic        done_int_o;

    int n_assert = 0;
    int n_fail   = 0;
    int gnt_delay = 0;
    logic [31:0] seed;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t log_q[$];

    conv1d_feeder dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_wstrb_i(reg_wstrb_i),
        .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
        .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o),
        .mgr_req_o(mgr_req_o), .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o),
        .mgr_addr_o(mgr_addr_o), .mgr_wdata_o(mgr_wdata_o),
        .mgr_gnt_i(mgr_gnt_i), .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i),
        .done_int_o(done_int_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // OBI subordinate: grants after gnt_delay waiting cycles, responds the cycle after grant.
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    int          hold_cnt = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    always @(negedge clk) begin
        mgr_rvalid_i = pend;
        mgr_rdata_i  = pend ? pend_data : 32'd0;
        pend         = 1'b0;
        mgr_gnt_i    = 1'b0;
        if (mgr_req_o) begin
            if (hold_cnt == 0) begin
                h_we = mgr_we_o; h_addr = mgr_addr_o; h_wdata = mgr_wdata_o;
            end else begin
                chk("hold_we", {31'd0, mgr_we_o}, {31'd0, h_we});
                chk("hold_addr", mgr_addr_o, h_addr);
                if (h_we) chk("hold_wdata", mgr_wdata_o, h_wdata);
            end
            if (hold_cnt >= gnt_delay) begin
                mgr_gnt_i = 1'b1;
                chk("be", {28'd0, mgr_be_o}, 32'hF);
                pend      = 1'b1;
                pend_data = mgr_we_o ? 32'd0 : mem_f(mgr_addr_o);
                log_q.push_back('{we: mgr_we_o, addr: mgr_addr_o,
                                  data: mgr_we_o ? mgr_wdata_o : pend_data});
                hold_cnt = 0;
            end else begin
                hold_cnt++;
            end
        end else begin
            hold_cnt = 0;
        end
    end

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        reg_valid_i = 1'b1; reg_write_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
        #1 e = reg_error_o;
        @(posedge clk);
        #1 reg_valid_i = 1'b0; reg_write_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = a;
        #1 d = reg_rdata_o; e = reg_error_o;
        @(posedge clk);
        #1 reg_valid_i = 1'b0;
    endtask

    task automatic program_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        logic e;
        reg_wr(32'h08, s, e);
        reg_wr(32'h0C, d, e);
        reg_wr(32'h10, n, e);
        reg_wr(32'h00, 32'h2, e);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done_int_o && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        chk("done_seen", {31'd0, done_int_o}, 32'd1);
    endtask

    // Reference: word i is read from s+4i, then written unchanged to d+4i, in order.
    task automatic check_xfer(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] ra, wa;
        chk({tag, "_ntxn"}, log_q.size(), 2 * n);
        for (int i = 0; i < n && 2 * i + 1 < log_q.size(); i++) begin
            ra = s + 32'(4 * i);
            wa = d + 32'(4 * i);
            chk({tag, "_rd_we"}, {31'd0, log_q[2*i].we}, 32'd0);
            chk({tag, "_rd_addr"}, log_q[2*i].addr, ra);
            chk({tag, "_wr_we"}, {31'd0, log_q[2*i+1].we}, 32'd1);
            chk({tag, "_wr_addr"}, log_q[2*i+1].addr, wa);
            chk({tag, "_wr_data"}, log_q[2*i+1].data, mem_f(ra));
        end
        log_q.delete();
    endtask

    initial begin
        logic        e;
        logic [31:0] d;
        int          n;
        logic [31:0] rs, rdst;
        int          rl;
        bit          found;

        seed = $urandom;
        rst_ni = 1'b0;
        reg_valid_i = 1'b0; reg_write_i = 1'b0; reg_wstrb_i = 4'hF;
        reg_addr_i = '0; reg_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mgr_req_o}, 32'd0);
        chk("rst_done_int", {31'd0, done_int_o}, 32'd0);
        chk("rst_addr", mgr_addr_o, 32'd0);
        @(negedge clk) rst_ni = 1'b1;
        reg_rd(32'h04, d, e); chk("rst_status", d, 32'd0);
        reg_rd(32'h08, d, e); chk("rst_src", d, 32'd0);
        reg_rd(32'h10, d, e); chk("rst_len", d, 32'd0);
        reg_rd(32'h00, d, e); chk("rst_ctrl", d, 32'd0);

        // Basic 4-word copy, zero-wait memory
        gnt_delay = 0;
        program_xfer(32'h1000, 32'h2000, 4);
        log_q.delete();
        reg_wr(32'h00, 32'h3, e);
        wait_done(200, n);
        chk("t1_cycles", n, 32'd16);
        @(posedge clk); #1;
        chk("t1_pulse_single", {31'd0, done_int_o}, 32'd0);
        reg_rd(32'h04, d, e); chk("t1_status", d, 32'h2);
        reg_rd(32'h00, d, e); chk("t1_ctrl_rd", d, 32'h2);
        check_xfer("t1", 32'h1000, 32'h2000, 4);

        // Delayed grant
        gnt_delay = 3;
        program_xfer(32'h3000, 32'h4000, 3);
        log_q.delete();
        reg_wr(32'h00, 32'h3, e);
        wait_done(500, n);
        chk("t2_cycles", n, 32'd30);
        check_xfer("t2", 32'h3000, 32'h4000, 3);

        // Zero length, W1C colliding with DONE, LEN clamping
        gnt_delay = 0;
        reg_wr(32'h10, 32'd0, e);
        reg_wr(32'h00, 32'h3, e);
        #0;
        chk("t3_len0_done", {31'd0, done_int_o}, 32'd1);
        reg_wr(32'h04, 32'h2, e);
        reg_rd(32'h04, d, e); chk("t3_w1c_same_cycle", d, 32'h2);
        chk("t3_no_traffic", log_q.size(), 32'd0);
        reg_wr(32'h04, 32'h2, e);
        reg_rd(32'h04, d, e); chk("t5_w1c", d, 32'h0);
        reg_wr(32'h10, 32'd5000, e); reg_rd(32'h10, d, e); chk("t3_len5000", d, 32'd1024);
        reg_wr(32'h10, 32'd1025, e); reg_rd(32'h10, d, e); chk("t3_len1025", d, 32'd1024);
        reg_wr(32'h10, 32'd1024, e); reg_rd(32'h10, d, e); chk("t3_len1024", d, 32'd1024);

        // Accesses while busy
        gnt_delay = 2;
        program_xfer(32'h5000, 32'h6000, 3);
        log_q.delete();
        reg_wr(32'h00, 32'h3, e);
        reg_wr(32'h08, 32'h9990, e); chk("t4_src_err", {31'd0, e}, 32'd1);
        reg_rd(32'h08, d, e);        chk("t4_src_kept", d, 32'h5000);
        reg_rd(32'h04, d, e);        chk("t4_status_busy", d, 32'h1);
        reg_wr(32'h00, 32'h3, e);    chk("t4_restart_noerr", {31'd0, e}, 32'd0);
        reg_wr(32'h10, 32'd1, e);    chk("t4_len_err", {31'd0, e}, 32'd1);
        wait_done(500, n);
        check_xfer("t4", 32'h5000, 32'h6000, 3);

        // Bad offset, DST low bits
        reg_rd(32'h14, d, e); chk("t5_bad_off_err", {31'd0, e}, 32'd1);
        reg_wr(32'h0C, 32'h2003, e); chk("t5_dst_noerr", {31'd0, e}, 32'd0);
        reg_rd(32'h0C, d, e); chk("t5_dst_align", d, 32'h2000);

        // Reset in WR_REQ
        gnt_delay = 0;
        program_xfer(32'h7000, 32'h8000, 4);
        reg_wr(32'h00, 32'h3, e);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #1;
            if (mgr_req_o && mgr_we_o) found = 1'b1;
        end
        chk("t6_found_wr_req", {31'd0, found}, 32'd1);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        chk("t6_req_dropped", {31'd0, mgr_req_o}, 32'd0);
        @(negedge clk) rst_ni = 1'b1;
        reg_rd(32'h04, d, e); chk("t6_status", d, 32'd0);
        gnt_delay = 1;
        program_xfer(32'h7000, 32'h8000, 4);
        log_q.delete();
        reg_wr(32'h00, 32'h3, e);
        wait_done(500, n);
        chk("t6_cycles", n, 32'd24);
        check_xfer("t6", 32'h7000, 32'h8000, 4);

        // Randomized transfers, first one wrapping past the top of memory
        for (int k = 0; k < 3; k++) begin
            rs   = (k == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00};
            rdst = {$urandom, 2'b00};
            rl   = $urandom_range(1, 6);
            gnt_delay = $urandom_range(0, 3);
            program_xfer(rs, rdst, rl);
            log_q.delete();
            reg_wr(32'h00, 32'h3, e);
            wait_done(1000, n);
            chk("rnd_cycles", n, 32'(rl * (4 + 2 * gnt_delay)));
            check_xfer("rnd", rs, rdst, rl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
